// File: rtl/contact_record_reader_pkg.sv
// Shared definitions for the contact RAM reader: record geometry, default widths
// and FSM state encodings.
package contact_record_reader_pkg;

    localparam int REC_WORDS      = 7;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_LAST    = 3'd2,
        ST_PRESENT = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/contact_record_reader_if.sv
// Control, RAM read port and record stream of the contact reader.
// master = reader side, slave = the environment (RAM + requester + consumer).
interface contact_record_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH-1:0] rec_count;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_cs;
    logic                  mem_oe;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [DATA_WIDTH-1:0] rec_word0, rec_word1, rec_word2, rec_word3;
    logic [DATA_WIDTH-1:0] rec_word4, rec_word5, rec_word6;
    logic                  rec_valid;
    logic                  rec_ready;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        input  start, base_addr, rec_count, mem_rdata, rec_ready,
        output mem_addr, mem_cs, mem_oe, mem_we,
        output rec_word0, rec_word1, rec_word2, rec_word3, rec_word4, rec_word5, rec_word6,
        output rec_valid, busy, done, err
    );

    modport slave (
        output start, base_addr, rec_count, mem_rdata, rec_ready,
        input  mem_addr, mem_cs, mem_oe, mem_we,
        input  rec_word0, rec_word1, rec_word2, rec_word3, rec_word4, rec_word5, rec_word6,
        input  rec_valid, busy, done, err
    );
endinterface

// File: rtl/contact_record_reader.sv
// Walks the contact RAM one word per cycle, reassembles 7-word records and
// presents each one on a valid/ready handshake.
module contact_record_reader
    import contact_record_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int RAM_DEPTH  = 32
) (
    input logic                    clk,
    input logic                    rst,
    contact_record_reader_if.master bus
);

    localparam int EXT_W = ADDR_WIDTH + 4;

    state_t                                  state;
    logic [ADDR_WIDTH-1:0]                   base_q, count_q, rec_idx;
    logic [2:0]                              word_idx;
    logic [REC_WORDS-1:0][DATA_WIDTH-1:0]    rec_q;
    logic [ADDR_WIDTH-1:0]                   rec_off, rec_nxt, nxt_off;
    logic [EXT_W-1:0]                        cnt_ext, end_addr;

    // x*7 as (x<<3)-x; the range check is widened so it cannot wrap
    always_comb begin
        rec_off  = (rec_idx << 3) - rec_idx;
        rec_nxt  = rec_idx + ADDR_WIDTH'(1);
        nxt_off  = (rec_nxt << 3) - rec_nxt;
        cnt_ext  = {4'b0, bus.rec_count};
        end_addr = {4'b0, bus.base_addr} + (cnt_ext << 3) - cnt_ext;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            base_q        <= '0;
            count_q       <= '0;
            rec_idx       <= '0;
            word_idx      <= '0;
            rec_q         <= '0;
            bus.mem_addr  <= '0;
            bus.mem_cs    <= 1'b0;
            bus.mem_oe    <= 1'b0;
            bus.rec_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            bus.err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (end_addr > EXT_W'(RAM_DEPTH)) begin
                            bus.err <= 1'b1;
                        end else if (bus.rec_count == '0) begin
                            state    <= ST_DONE;
                            bus.busy <= 1'b1;
                            bus.done <= 1'b1;
                        end else begin
                            state        <= ST_READ;
                            base_q       <= bus.base_addr;
                            count_q      <= bus.rec_count;
                            rec_idx      <= '0;
                            word_idx     <= '0;
                            bus.mem_addr <= bus.base_addr;
                            bus.mem_cs   <= 1'b1;
                            bus.mem_oe   <= 1'b1;
                            bus.busy     <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    // RAM data lags the address by one cycle
                    if (word_idx != 3'd0)
                        rec_q[word_idx - 3'd1] <= bus.mem_rdata;
                    if (word_idx == 3'(REC_WORDS - 1)) begin
                        state <= ST_LAST;
                    end else begin
                        word_idx     <= word_idx + 3'd1;
                        bus.mem_addr <= base_q + rec_off + ADDR_WIDTH'(word_idx) + ADDR_WIDTH'(1);
                    end
                end
                ST_LAST: begin
                    rec_q[REC_WORDS-1] <= bus.mem_rdata;
                    bus.mem_cs         <= 1'b0;
                    bus.mem_oe         <= 1'b0;
                    bus.rec_valid      <= 1'b1;
                    state              <= ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (bus.rec_ready) begin
                        bus.rec_valid <= 1'b0;
                        if (rec_idx == count_q - ADDR_WIDTH'(1)) begin
                            state    <= ST_DONE;
                            bus.done <= 1'b1;
                        end else begin
                            state        <= ST_READ;
                            rec_idx      <= rec_nxt;
                            word_idx     <= '0;
                            bus.mem_addr <= base_q + nxt_off;
                            bus.mem_cs   <= 1'b1;
                            bus.mem_oe   <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_we    = 1'b0;
    assign bus.rec_word0 = rec_q[0];
    assign bus.rec_word1 = rec_q[1];
    assign bus.rec_word2 = rec_q[2];
    assign bus.rec_word3 = rec_q[3];
    assign bus.rec_word4 = rec_q[4];
    assign bus.rec_word5 = rec_q[5];
    assign bus.rec_word6 = rec_q[6];

endmodule
